// File: rtl/dual_debounce_pkg.sv
// Shared definitions for the two-channel switch debouncer.
//   db_state_e : 3-bit FSM state encoding. Bit 2 is the debounced level, so
//                ZERO/W1_k read 0 and ONE/W0_k read 1.
//   NUM_CH     : number of debounced channels (a, b).
//   db_level() : debounced level implied by a state.
package dual_debounce_pkg;

    typedef enum logic [2:0] {
        ST_ZERO = 3'd0,
        ST_W1_1 = 3'd1,
        ST_W1_2 = 3'd2,
        ST_W1_3 = 3'd3,
        ST_ONE  = 3'd4,
        ST_W0_1 = 3'd5,
        ST_W0_2 = 3'd6,
        ST_W0_3 = 3'd7
    } db_state_e;

    localparam int NUM_CH = 2;

    function automatic logic db_level(input db_state_e s);
        return s[2];
    endfunction

endpackage

// File: rtl/dual_debounce_if.sv
// Switch-side bundle of the debouncer.
//   sw_a/sw_b     : raw, asynchronous, bouncy switch levels (master drives)
//   db_a/db_b     : debounced levels (slave drives)
//   rise_a/rise_b : 1-cycle pulses on debounced 0->1 (slave drives)
interface dual_debounce_if;
    logic sw_a;
    logic sw_b;
    logic db_a;
    logic db_b;
    logic rise_a;
    logic rise_b;

    modport master (output sw_a, sw_b, input db_a, db_b, rise_a, rise_b);
    modport slave  (input sw_a, sw_b, output db_a, db_b, rise_a, rise_b);
endinterface

// File: rtl/dual_debounce_db_fsm_chan.sv
// One debounce channel: 2-flop synchroniser, 8-state tick-paced filter FSM,
// registered debounced level and rising-edge pulse.
//   clk, reset : system clock, synchronous active-high reset
//   sw         : raw asynchronous switch input
//   m_tick     : shared 1-cycle pacing tick
//   db         : debounced level
//   rise       : 1-cycle pulse in the first cycle db reads 1
module db_fsm_chan
    import dual_debounce_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic m_tick,
    output logic db,
    output logic rise
);

    logic [1:0] sync_q;
    logic       s;
    db_state_e  state_q, state_d;
    logic       db_q, rise_q;

    assign s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], sw};
    end

    // Input disagreement is tested before the tick so a bounce landing on a
    // tick cycle still restarts the wait.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ZERO: if (s) state_d = ST_W1_1;
            ST_W1_1: if (!s) state_d = ST_ZERO; else if (m_tick) state_d = ST_W1_2;
            ST_W1_2: if (!s) state_d = ST_ZERO; else if (m_tick) state_d = ST_W1_3;
            ST_W1_3: if (!s) state_d = ST_ZERO; else if (m_tick) state_d = ST_ONE;
            ST_ONE:  if (!s) state_d = ST_W0_1;
            ST_W0_1: if (s)  state_d = ST_ONE;  else if (m_tick) state_d = ST_W0_2;
            ST_W0_2: if (s)  state_d = ST_ONE;  else if (m_tick) state_d = ST_W0_3;
            ST_W0_3: if (s)  state_d = ST_ONE;  else if (m_tick) state_d = ST_ZERO;
            default: state_d = ST_ZERO;
        endcase
    end

    // db/rise are loaded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ZERO;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_level(state_d);
            rise_q  <= db_level(state_d) & ~db_q;
        end
    end

    assign db   = db_q;
    assign rise = rise_q;

endmodule

// File: rtl/dual_debounce.sv
// Two-channel switch debouncer. A free-running N-bit counter produces a tick
// every 2^N cycles, shared by both channel filters.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of dual_debounce_if (sw_* in; db_*, rise_* out)
module dual_debounce
    import dual_debounce_pkg::*;
#(
    parameter int N = 19
) (
    input  logic            clk,
    input  logic            reset,
    dual_debounce_if.slave  bus
);

    logic [N-1:0]        cnt_q;
    logic                m_tick;
    logic [NUM_CH-1:0]   sw, db, rise;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + {{(N-1){1'b0}}, 1'b1};
    end

    assign m_tick = (cnt_q == '0);

    assign sw = {bus.sw_b, bus.sw_a};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        db_fsm_chan u_chan (
            .clk    (clk),
            .reset  (reset),
            .sw     (sw[i]),
            .m_tick (m_tick),
            .db     (db[i]),
            .rise   (rise[i])
        );
    end

    assign bus.db_a   = db[0];
    assign bus.db_b   = db[1];
    assign bus.rise_a = rise[0];
    assign bus.rise_b = rise[1];

endmodule

// File: tb/tb_dual_debounce.sv
module tb_dual_debounce;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dual_debounce_if bus();

    dual_debounce #(.N(N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc cycles, recording the first cycle each db output changes, the
    // number of db toggles and rise pulses, and rise pulses that do not sit
    // exactly on a db 0->1 (or db 0->1 without a pulse).
    task automatic run(input int ncyc,
                       output int chg_a, output int chg_b,
                       output int tg_a,  output int tg_b,
                       output int nr_a,  output int nr_b,
                       output int bad);
        logic pa, pb;
        pa = bus.db_a; pb = bus.db_b;
        chg_a = -1; chg_b = -1; tg_a = 0; tg_b = 0; nr_a = 0; nr_b = 0; bad = 0;
        for (int i = 1; i <= ncyc; i++) begin
            cyc();
            if (bus.db_a !== pa) begin tg_a++; if (chg_a < 0) chg_a = i; end
            if (bus.db_b !== pb) begin tg_b++; if (chg_b < 0) chg_b = i; end
            if (bus.rise_a === 1'b1) nr_a++;
            if (bus.rise_b === 1'b1) nr_b++;
            if (bus.rise_a !== (bus.db_a === 1'b1 && pa === 1'b0)) bad++;
            if (bus.rise_b !== (bus.db_b === 1'b1 && pb === 1'b0)) bad++;
            pa = bus.db_a; pb = bus.db_b;
        end
    endtask

    int ca, cb, ta, tb, ra, rb, bd;
    int acc_ta, acc_ra, acc_bd;

    initial begin
        // 1: reset held with switches high; outputs stay low
        reset = 1'b1; bus.sw_a = 1'b1; bus.sw_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_db_a",   bus.db_a,   0);
            chk("rst_db_b",   bus.db_b,   0);
            chk("rst_rise",   {bus.rise_a, bus.rise_b}, 0);
        end
        reset = 1'b0; bus.sw_a = 1'b0; bus.sw_b = 1'b0;
        run(6, ca, cb, ta, tb, ra, rb, bd);
        chk("idle_db", {bus.db_a, bus.db_b}, 0);

        // 2: sw_a rises and holds
        bus.sw_a = 1'b1;
        run(40, ca, cb, ta, tb, ra, rb, bd);
        chk("t2_lat_in_range", (ca >= 19 && ca <= 27), 1);
        chk("t2_toggles_a", ta, 1);
        chk("t2_rise_a_cnt", ra, 1);
        chk("t2_rise_align", bd, 0);
        chk("t2_db_b_quiet", tb, 0);
        chk("t2_db_a_final", bus.db_a, 1);

        // 4: sw_a falls and holds; no pulse on the falling edge
        bus.sw_a = 1'b0;
        run(40, ca, cb, ta, tb, ra, rb, bd);
        chk("t4_lat_in_range", (ca >= 19 && ca <= 27), 1);
        chk("t4_toggles_a", ta, 1);
        chk("t4_rise_a_cnt", ra, 0);
        chk("t4_db_a_final", bus.db_a, 0);

        // 3: bouncing sw_a, 10 high / 2 low, five times
        acc_ta = 0; acc_ra = 0; acc_bd = 0;
        for (int r = 0; r < 5; r++) begin
            bus.sw_a = 1'b1;
            run(10, ca, cb, ta, tb, ra, rb, bd);
            acc_ta += ta; acc_ra += ra; acc_bd += bd;
            bus.sw_a = 1'b0;
            run(2, ca, cb, ta, tb, ra, rb, bd);
            acc_ta += ta; acc_ra += ra; acc_bd += bd;
        end
        run(30, ca, cb, ta, tb, ra, rb, bd);
        acc_ta += ta; acc_ra += ra; acc_bd += bd;
        chk("t3_db_a_toggles", acc_ta, 0);
        chk("t3_rise_a_cnt", acc_ra, 0);
        chk("t3_rise_align", acc_bd, 0);
        chk("t3_db_a_final", bus.db_a, 0);

        // 5: both switches rise in the same cycle
        bus.sw_a = 1'b1; bus.sw_b = 1'b1;
        run(40, ca, cb, ta, tb, ra, rb, bd);
        chk("t5_same_cycle", (ca == cb), 1);
        chk("t5_lat_in_range", (ca >= 19 && ca <= 27), 1);
        chk("t5_rise_cnt", {ra[15:0], rb[15:0]}, {16'd1, 16'd1});
        chk("t5_rise_align", bd, 0);
        chk("t5_db_final", {bus.db_a, bus.db_b}, 2'b11);

        // 6: sw_b mid-wait interrupted by reset, then re-debounced
        bus.sw_a = 1'b0; bus.sw_b = 1'b0;
        run(40, ca, cb, ta, tb, ra, rb, bd);
        chk("t6_cleared", {bus.db_a, bus.db_b}, 0);
        bus.sw_b = 1'b1;
        run(12, ca, cb, ta, tb, ra, rb, bd);
        chk("t6_pre_reset_db_b", bus.db_b, 0);
        reset = 1'b1;
        cyc();
        chk("t6_reset_db_b", bus.db_b, 0);
        chk("t6_reset_rise_b", bus.rise_b, 0);
        reset = 1'b0;
        run(40, ca, cb, ta, tb, ra, rb, bd);
        chk("t6_lat_in_range", (cb >= 19 && cb <= 27), 1);
        chk("t6_rise_b_cnt", rb, 1);
        chk("t6_rise_align", bd, 0);
        chk("t6_db_a_quiet", ta, 0);
        chk("t6_db_b_final", bus.db_b, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
